// File: rtl/instr_decode_buffer.sv
// Decoded-instruction FIFO: RV32 words are decoded at enqueue and the decoded record is queued.
// Optional macro DECODE_SYSTEM_EN makes the SYSTEM opcode decode as an I-format instruction.
module instr_decode_buffer #(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [PC_WIDTH-1:0]        in_pc,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic [6:0]                 out_opcode,
    output logic [2:0]                 out_fmt,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [2:0]                 out_funct3,
    output logic [6:0]                 out_funct7,
    output logic [31:0]                out_imm,
    output logic                       out_illegal
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [6:0]          opcode;
        logic [2:0]          fmt;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [31:0]         imm;
        logic                illegal;
    } dec_t;

    dec_t           mem_q [DEPTH];
    dec_t           mem_d [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    dec_t           dec;
    dec_t           head;
    logic           push, pop;

    always_comb begin
        dec        = '0;
        dec.pc     = in_pc;
        dec.opcode = in_instr[6:0];
        dec.rd     = in_instr[11:7];
        dec.funct3 = in_instr[14:12];
        dec.rs1    = in_instr[19:15];
        dec.rs2    = in_instr[24:20];
        dec.funct7 = in_instr[31:25];
        case (in_instr[6:0])
            OPC_OP:                                     dec.fmt = FMT_R;
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM: dec.fmt = FMT_I;
`ifdef DECODE_SYSTEM_EN
            OPC_SYSTEM:                                 dec.fmt = FMT_I;
`else
            OPC_SYSTEM:                                 dec.fmt = FMT_NONE;
`endif
            OPC_STORE:                                  dec.fmt = FMT_S;
            OPC_BRANCH:                                 dec.fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:                         dec.fmt = FMT_U;
            OPC_JAL:                                    dec.fmt = FMT_J;
            default:                                    dec.fmt = FMT_NONE;
        endcase
        if (dec.fmt != FMT_R) dec.funct7 = '0;
        case (dec.fmt)
            FMT_I: begin
                dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
                dec.rs2 = '0;
            end
            FMT_S: begin
                dec.imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                dec.rd  = '0;
            end
            FMT_B: begin
                dec.imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
                dec.rd  = '0;
            end
            FMT_U, FMT_J: begin
                dec.imm    = (dec.fmt == FMT_U) ? {in_instr[31:12], 12'b0}
                           : {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0};
                dec.rs1    = '0;
                dec.rs2    = '0;
                dec.funct3 = '0;
            end
            default: dec.imm = '0;
        endcase
        // Illegal entries keep only opcode and pc so downstream can report the fault address.
        if (in_instr[1:0] != 2'b11 || dec.fmt == FMT_NONE) begin
            dec.fmt     = FMT_NONE;
            dec.rd      = '0;
            dec.rs1     = '0;
            dec.rs2     = '0;
            dec.funct3  = '0;
            dec.funct7  = '0;
            dec.imm     = '0;
            dec.illegal = 1'b1;
        end
    end

    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = dec;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop) count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the buffer is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head        = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_pc      = head.pc;
    assign out_opcode  = head.opcode;
    assign out_fmt     = head.fmt;
    assign out_rd      = head.rd;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_funct3  = head.funct3;
    assign out_funct7  = head.funct7;
    assign out_imm     = head.imm;
    assign out_illegal = head.illegal;
endmodule

// File: doc/instr_decode_buffer.md
INSTR_DECODE_BUFFER -- requirements
Module: instr_decode_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning decoded-entry capacity (power of two, >= 2).
REQ-002 SHALL have parameter PC_WIDTH, default 32, meaning width of carried program-counter tag.
REQ-003 SHALL have one clock and a synchronous, active-high reset; ports in order: clk input 1 (rising-edge clock); reset input 1 (synchronous, active-high reset).
REQ-004 SHALL have ports: in_valid input 1 (fetch word valid); in_ready output 1 (buffer can accept); in_instr input 32 (raw instruction word); in_pc input PC_WIDTH (fetch address).
REQ-005 SHALL have ports: flush input 1 (discard all entries); count output $clog2(DEPTH)+1 (occupied entries).
REQ-006 SHALL have ports: out_valid output 1; out_ready input 1; out_pc output PC_WIDTH; out_opcode output 7; out_fmt output 3 (0=R,1=I,2=S,3=B,4=U,5=J,7=NONE); out_rd, out_rs1, out_rs2 output 5 each; out_funct3 output 3; out_funct7 output 7; out_imm output 32 (sign-extended immediate); out_illegal output 1.

Function
REQ-007 SHALL decode each word at enqueue and store the decoded record, not the raw word, in a circular buffer of DEPTH entries.
REQ-008 SHALL accept a word when in_valid && in_ready; in_ready SHALL equal (count < DEPTH), with no same-cycle pass-through when full.
REQ-009 SHALL drive out_* from the head entry; out_valid = (count != 0); pop occurs on out_valid && out_ready.
REQ-010 SHALL present an accepted word on out_* exactly one cycle after acceptance when the buffer was empty (latency 1).
REQ-011 SHALL update count by +1 on push only, -1 on pop only, unchanged on simultaneous push and pop; read/write pointers wrap modulo DEPTH.
REQ-012 SHALL, on flush, set count and both pointers to 0 at the next edge; flush has priority over push and pop in the same cycle.
REQ-013 SHALL classify format: OP->R; LOAD, OP_IMM, JALR, MISC_MEM, SYSTEM->I; STORE->S; BRANCH->B; LUI, AUIPC->U; JAL->J; all others->NONE.
REQ-014 SHALL form immediates: I = sext(inst[31:20]); S = sext({inst[31:25],inst[11:7]}); B = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}); U = {inst[31:12],12'b0}; J = sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}); R/NONE = 0.
REQ-015 SHALL zero out_rd for S/B, out_rs2 for I/U/J, out_rs1 for U/J, out_funct3 for U/J, and out_funct7 unless format is R.
REQ-016 SHALL set out_illegal when inst[1:0] != 2'b11 or format is NONE; illegal entries carry fmt=7, all register fields, funct fields and imm zero, opcode and pc preserved.
REQ-017 SHALL hold all out_* stable while out_valid && !out_ready.

Reset
REQ-018 SHALL, on reset, set count=0, pointers=0, out_valid=0, in_ready=1; out_* data SHALL read 0 while buffer is empty.
REQ-019 SHALL treat reset asserted mid-operation like flush, discarding in-flight entries with no partial pop; reset overrides flush, push, pop.

Configuration
REQ-020 SHALL support macro DECODE_SYSTEM_EN: defined -> SYSTEM opcode decodes as I format (csr address in imm, rs1 carries uimm); undefined -> SYSTEM opcode is illegal per REQ-016.

Verification
REQ-021 SHALL cover: push 0xFFF00093 (addi x1,x0,-1) pc=0x100 -> next cycle out_valid=1, fmt=1, rd=1, rs1=0, imm=0xFFFFFFFF, illegal=0.
REQ-022 SHALL cover: push 0x0020A223 (sw x2,4(x1)), 0x123452B7 (lui x5,0x12345), 0xFFDFF06F (jal x0,-4) -> fmt 2/imm 0x4/rs2=2/rd=0; fmt 4/imm 0x12345000/rd=5; fmt 5/imm 0xFFFFFFFC, in push order.
REQ-023 SHALL cover: DEPTH=4, out_ready=0, push 5 words -> in_ready=0 after 4th, count=4, 5th not accepted; then out_ready=1 drains 4 in order, count reaches 0.
REQ-024 SHALL cover: count=2 with push, pop and flush in same cycle -> count=0, out_valid=0 next cycle, pushed word discarded.
REQ-025 SHALL cover: push 0x00000073 (ecall) and 0x00000013 with bit1 cleared (0x00000011) -> ecall legal fmt=1 with DECODE_SYSTEM_EN, illegal without; 0x00000011 illegal=1, fmt=7 in both builds.
REQ-026 SHALL cover: simultaneous push and pop at count=3 for 8 cycles -> count stays 3, pointers wrap, output order matches input order.
